// File: rtl/bru_pkg.sv
// bru_pkg: shared types and constants for branch_recover_unit.
//   RESET_PC     - redirect PC value held out of reset
//   ctr_e        - 2-bit saturating counter encodings
//   bq_entry_t   - in-flight branch record (pred_idx only with BRU_BHT_EN)
//   ctr_next()   - saturating counter update
// Optional feature macro: BRU_BHT_EN (16-entry PC-indexed counter table).
package bru_pkg;

  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam int          BHT_ENTRIES = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] target_pc;
    logic [31:0] fall_pc;
`ifdef BRU_BHT_EN
    logic [3:0]  pred_idx;
`endif
  } bq_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == STRONG_T)  ? c : c + 2'd1;
    else       return (c == STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bru_queue.sv
// bru_queue: circular FIFO of in-flight predicted branches.
//   clk, rst_n         clock / async active-low reset
//   push, push_data    write one entry at tail (caller guarantees room)
//   pop                retire head entry (caller guarantees non-empty)
//   clear              drop all entries; overrides push/pop
//   head               oldest entry (undefined when empty)
//   count, full, empty occupancy, all from registered state
module bru_queue
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  bq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     clear,
  output bq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  bq_entry_t         mem [DEPTH];
  logic [PW-1:0]     head_ptr, tail_ptr;
  logic [PW:0]       cnt;

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_ptr] <= push_data;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else if (clear) begin
      head_ptr <= tail_ptr;
      cnt      <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[head_ptr];
  assign count = cnt;
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/branch_recover_unit.sv
// branch_recover_unit: resolves fetch-time branch predictions in program order
// and issues a one-cycle redirect on a misprediction. Also owns the 2-bit
// saturating predictor feeding branch_predict_result back to fetch.
//   clk, rst_n                           clock / async active-low reset
//   fetch_pc -> branch_predict_result    combinational prediction lookup
//   bq_push, bq_pred_taken, bq_target_pc, bq_fall_pc   enqueue a branch
//   bq_full, bq_count                    queue occupancy (registered)
//   res_valid, res_taken                 execute outcome for the oldest branch
//   recover_en, recover_pc               registered redirect pulse + PC
//   res_err                              sticky protocol error
// Optional feature macro: BRU_BHT_EN selects a 16-entry table indexed by
// fetch_pc[5:2]; otherwise a single global counter is used.
module branch_recover_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              fetch_pc,
  output logic                     branch_predict_result,
  input  logic                     bq_push,
  input  logic                     bq_pred_taken,
  input  logic [31:0]              bq_target_pc,
  input  logic [31:0]              bq_fall_pc,
  output logic                     bq_full,
  output logic [$clog2(DEPTH):0]   bq_count,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     recover_en,
  output logic [31:0]              recover_pc,
  output logic                     res_err
);

  bq_entry_t head, push_entry;
  logic      q_empty, q_full;
  logic      head_ok, mispredict_now, pop_now;
  logic      push_ctx, push_acc, err_set;

  assign head_ok        = res_valid && !q_empty;
  assign mispredict_now = head_ok && (res_taken != head.pred_taken);
  assign pop_now        = head_ok && !mispredict_now;

  // Pushes in the redirect cycle or alongside a mispredict are wrong-path:
  // discarded without flagging an error.
  assign push_ctx = bq_push && !recover_en && !mispredict_now;
  assign push_acc = push_ctx && (!q_full || pop_now);
  assign err_set  = (res_valid && q_empty) || (push_ctx && q_full && !pop_now);

  bru_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_acc),
    .push_data (push_entry),
    .pop       (pop_now),
    .clear     (mispredict_now),
    .head      (head),
    .count     (bq_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bq_full = q_full;

`ifdef BRU_BHT_EN
  logic [1:0] bht [BHT_ENTRIES];
  logic [3:0] fetch_idx;
  logic       unused_pc_bits;

  assign fetch_idx      = fetch_pc[5:2];
  assign unused_pc_bits = ^{fetch_pc[31:6], fetch_pc[1:0]};

  // Only the counter that produced the head's prediction is trained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WEAK_NT;
    end else if (head_ok) begin
      bht[head.pred_idx] <= ctr_next(bht[head.pred_idx], res_taken);
    end
  end

  assign branch_predict_result = bht[fetch_idx][1];
`else
  logic [1:0] gctr;
  logic       unused_fetch_pc;

  assign unused_fetch_pc = ^fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       gctr <= WEAK_NT;
    else if (head_ok) gctr <= ctr_next(gctr, res_taken);
  end

  assign branch_predict_result = gctr[1];
`endif

  always_comb begin
    push_entry            = '0;
    push_entry.pred_taken = bq_pred_taken;
    push_entry.target_pc  = bq_target_pc;
    push_entry.fall_pc    = bq_fall_pc;
`ifdef BRU_BHT_EN
    push_entry.pred_idx   = fetch_idx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recover_en <= 1'b0;
      recover_pc <= RESET_PC;
      res_err    <= 1'b0;
    end else begin
      recover_en <= mispredict_now;
      if (mispredict_now) recover_pc <= res_taken ? head.target_pc : head.fall_pc;
      if (err_set)        res_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_recover_unit.sv
module tb_branch_recover_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        branch_predict_result;
  logic        bq_push = 1'b0, bq_pred_taken = 1'b0;
  logic [31:0] bq_target_pc = '0, bq_fall_pc = '0;
  logic        bq_full;
  logic [2:0]  bq_count;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic        recover_en;
  logic [31:0] recover_pc;
  logic        res_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  branch_recover_unit #(.DEPTH(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .fetch_pc              (fetch_pc),
    .branch_predict_result (branch_predict_result),
    .bq_push               (bq_push),
    .bq_pred_taken         (bq_pred_taken),
    .bq_target_pc          (bq_target_pc),
    .bq_fall_pc            (bq_fall_pc),
    .bq_full               (bq_full),
    .bq_count              (bq_count),
    .res_valid             (res_valid),
    .res_taken             (res_taken),
    .recover_en            (recover_en),
    .recover_pc            (recover_pc),
    .res_err               (res_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard of expected redirects: cycle in which recover_en must be high.
  typedef struct {
    int          due;
    logic [31:0] pc;
  } sb_t;
  sb_t sb[$];

  initial forever begin
    @(negedge clk);
    if (recover_en) begin
      tests++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        fails++;
        $display("FAIL recover_en: unexpected pulse at cycle %0d (pc %h)", cyc, recover_pc);
      end else begin
        if (recover_pc !== sb[0].pc) begin
          fails++;
          $display("FAIL recover_pc: got %h, expected %h (cycle %0d)", recover_pc, sb[0].pc, cyc);
        end
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      tests++;
      fails++;
      $display("FAIL recover_en: missing pulse due cycle %0d, expected pc %h", sb[0].due, sb[0].pc);
      void'(sb.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bq_push = 0; bq_pred_taken = 0; bq_target_pc = '0; bq_fall_pc = '0;
    res_valid = 0; res_taken = 0;
  endtask

  typedef struct {
    logic        rst, push, pt;
    logic [31:0] tgt, fall;
    logic        rv, rt;
    int          cnt;
    logic        full, err, bpr, rec;
    logic [31:0] rpc;
  } vec_t;

  function automatic vec_t V(input logic rst, push, pt, input logic [31:0] tgt, fall,
                             input logic rv, rt, input int cnt,
                             input logic full, err, bpr, rec, input logic [31:0] rpc);
    vec_t v;
    v.rst = rst; v.push = push; v.pt = pt; v.tgt = tgt; v.fall = fall;
    v.rv = rv; v.rt = rt; v.cnt = cnt; v.full = full; v.err = err;
    v.bpr = bpr; v.rec = rec; v.rpc = rpc;
    return v;
  endfunction

  // One table step: drive for one cycle (or reset), then check registered outputs.
  task automatic apply(input vec_t v, input int i);
    if (v.rst) begin
      idle_inputs();
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      sb.delete();
    end else begin
      bq_push = v.push; bq_pred_taken = v.pt; bq_target_pc = v.tgt; bq_fall_pc = v.fall;
      res_valid = v.rv; res_taken = v.rt;
      if (v.rec) sb.push_back('{cyc + 1, v.rpc});
      @(posedge clk); #1;
      idle_inputs();
    end
    chk($sformatf("v%0d.count", i), 32'(bq_count), 32'(v.cnt));
    chk($sformatf("v%0d.full", i),  32'(bq_full),  32'(v.full));
    chk($sformatf("v%0d.err", i),   32'(res_err),  32'(v.err));
    chk($sformatf("v%0d.pred", i),  32'(branch_predict_result), 32'(v.bpr));
  endtask

  task automatic cycle_drive(input logic push, pt, input logic [31:0] tgt, fall,
                             input logic rv, rt);
    bq_push = push; bq_pred_taken = pt; bq_target_pc = tgt; bq_fall_pc = fall;
    res_valid = rv; res_taken = rt;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  vec_t tbl[$];

  initial begin
    //        rst push pt tgt           fall          rv rt cnt full err bpr rec rpc
    tbl.push_back(V(1, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 0, 32'h80000100, 32'h80000008, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 0, 0, 0, 1, 1, 32'h80000100));
    tbl.push_back(V(0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000200, 32'h80000014, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000300, 32'h80000024, 0, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 32'h80000400, 32'h80000034, 0, 0, 3, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000500, 32'h80000044, 0, 0, 4, 1, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'hDEAD0000, 32'hDEAD0004, 0, 0, 4, 1, 1, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 32'h80000600, 32'h80000054, 1, 1, 4, 1, 1, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 3, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 0, 2, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 0, 0, 1, 1, 1, 32'h80000600));
    tbl.push_back(V(0, 0, 0, 0,            0,            0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(1, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000700, 32'h80000064, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 0, 32'h80000800, 32'h80000074, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000900, 32'h80000084, 0, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 1, 32'h80000A00, 32'h80000094, 1, 0, 0, 0, 0, 0, 1, 32'h80000064));
    tbl.push_back(V(0, 1, 1, 32'h80000B00, 32'h800000A4, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,            0,            1, 1, 0, 0, 1, 0, 0, 0));

    // Reset state.
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.recover_en", 32'(recover_en), 32'd0);
    chk("rst.recover_pc", recover_pc, 32'h80000000);
    chk("rst.count", 32'(bq_count), 32'd0);
    chk("rst.full", 32'(bq_full), 32'd0);
    chk("rst.err", 32'(res_err), 32'd0);
    chk("rst.pred", 32'(branch_predict_result), 32'd0);
    rst_n = 1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset while a redirect is in flight cancels it.
    apply(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    cycle_drive(1, 0, 32'h80000C00, 32'h800000B4, 0, 0);
    cycle_drive(0, 0, 0, 0, 1, 1);
    chk("mid.recover_en_pre", 32'(recover_en), 32'd1);
    chk("mid.recover_pc_pre", recover_pc, 32'h80000C00);
    rst_n = 0;
    #1;
    chk("mid.recover_en", 32'(recover_en), 32'd0);
    chk("mid.recover_pc", recover_pc, 32'h80000000);
    chk("mid.count", 32'(bq_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

`ifdef BRU_BHT_EN
    // Train index 1 taken twice; index 2 stays weakly not-taken.
    fetch_pc = 32'h80000004;
    cycle_drive(1, 0, 32'h80000D00, 32'h80000008, 0, 0);
    sb.push_back('{cyc + 1, 32'h80000D00});
    cycle_drive(0, 0, 0, 0, 1, 1);
    cycle_drive(0, 0, 0, 0, 0, 0);
    chk("bht.mid_pred", 32'(branch_predict_result), 32'd1);
    cycle_drive(1, 1, 32'h80000D00, 32'h80000008, 0, 0);
    cycle_drive(0, 0, 0, 0, 1, 1);
    chk("bht.pred_idx1", 32'(branch_predict_result), 32'd1);
    fetch_pc = 32'h80000008;
    #1;
    chk("bht.pred_idx2", 32'(branch_predict_result), 32'd0);
    fetch_pc = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
